// File: rtl/matrix_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : matrix_stream_tx
// Purpose  : Transmit side of the matrix-loader byte protocol. Buffers element
//            bytes, accepts a frame command with two matrix shapes, and emits
//            marker / four dimension bytes / all elements as one unbroken frame.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_stream_tx #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 4,
    parameter int DEPTH   = 32
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [7:0]                 cmd_r1,
    input  logic [7:0]                 cmd_c1,
    input  logic [7:0]                 cmd_r2,
    input  logic [7:0]                 cmd_c2,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          data_send,
    output logic [1:0]                 ctrl_logic,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int                 c_cnt_w    = $clog2(DEPTH + 1);
    localparam int                 c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]         c_max_dim  = 8'(MAX_DIM);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
    localparam logic [1:0]         c_code_elem = 2'd0;
    localparam logic [1:0]         c_code_dim  = 2'd1;
    localparam logic [1:0]         c_code_mark = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HDR  = 2'd2,
        S_DATA = 2'd3
    } state_t;

    state_t              state_q;
    logic [7:0]          r1_q, c1_q, r2_q, c2_q;
    logic [7:0]          total_q;
    logic [7:0]          elem_cnt_q;
    logic [1:0]          hdr_idx_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [c_ptr_w-1:0]  wr_ptr_q, rd_ptr_q;
    logic [c_cnt_w-1:0]  count_q, count_d;

    logic                cmd_ready_q, wr_ready_q, busy_q, done_q, err_q;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          ctrl_q;

    logic                w_push, w_pop, w_cmd_legal, w_fill_ok;
    logic [7:0]          w_cmd_total;
    logic [DATA_W-1:0]   w_hdr_next;

    // A frame may only start from a shape pair that can actually be multiplied.
    assign w_cmd_legal = (cmd_r1 != 8'd0) && (cmd_r1 <= c_max_dim) &&
                         (cmd_c1 != 8'd0) && (cmd_c1 <= c_max_dim) &&
                         (cmd_r2 != 8'd0) && (cmd_r2 <= c_max_dim) &&
                         (cmd_c2 != 8'd0) && (cmd_c2 <= c_max_dim) &&
                         (cmd_c1 == cmd_r2);
    assign w_cmd_total = (cmd_r1 * cmd_c1) + (cmd_r2 * cmd_c2);

    // Header is only released once every element is buffered, so DATA never stalls.
    assign w_fill_ok = (32'(count_q) >= 32'(total_q));

    assign w_push = wr_valid && wr_ready_q;
    // Pops line up with the edges that put an element on the bus.
    assign w_pop  = ((state_q == S_HDR)  && (hdr_idx_q == 2'd3)) ||
                    ((state_q == S_DATA) && (elem_cnt_q != total_q));

    // Selects the dimension byte that follows the one currently on the bus.
    always_comb begin
        w_hdr_next = DATA_W'(r1_q);
        case (hdr_idx_q)
            2'd0:    w_hdr_next = DATA_W'(c1_q);
            2'd1:    w_hdr_next = DATA_W'(r2_q);
            2'd2:    w_hdr_next = DATA_W'(c2_q);
            default: w_hdr_next = DATA_W'(r1_q);
        endcase
    end

    // Next occupancy: simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_cnt_w'(1);
        end
    end

    // Element storage; contents need no reset because the pointers define validity.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and the registered space-available flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            if (w_push) begin
                wr_ptr_q <= (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + c_ptr_w'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + c_ptr_w'(1);
            end
            count_q    <= count_d;
            wr_ready_q <= (count_d < c_depth);
        end
    end

    // Frame sequencer; every bus output is registered from the state being entered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            r1_q        <= '0;
            c1_q        <= '0;
            r2_q        <= '0;
            c2_q        <= '0;
            total_q     <= '0;
            elem_cnt_q  <= '0;
            hdr_idx_q   <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= '0;
            ctrl_q      <= c_code_mark;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (w_cmd_legal) begin
                            r1_q        <= cmd_r1;
                            c1_q        <= cmd_c1;
                            r2_q        <= cmd_r2;
                            c2_q        <= cmd_c2;
                            total_q     <= w_cmd_total;
                            state_q     <= S_WAIT;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_fill_ok) begin
                        state_q   <= S_HDR;
                        hdr_idx_q <= 2'd0;
                        ctrl_q    <= c_code_dim;
                        data_q    <= DATA_W'(r1_q);
                    end
                end
                S_HDR: begin
                    if (hdr_idx_q == 2'd3) begin
                        state_q    <= S_DATA;
                        ctrl_q     <= c_code_elem;
                        data_q     <= mem_q[rd_ptr_q];
                        elem_cnt_q <= 8'd1;
                        done_q     <= (total_q == 8'd1);
                    end else begin
                        hdr_idx_q <= hdr_idx_q + 2'd1;
                        data_q    <= w_hdr_next;
                    end
                end
                S_DATA: begin
                    if (elem_cnt_q == total_q) begin
                        state_q     <= S_IDLE;
                        ctrl_q      <= c_code_mark;
                        data_q      <= '0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        data_q     <= mem_q[rd_ptr_q];
                        elem_cnt_q <= elem_cnt_q + 8'd1;
                        done_q     <= ((elem_cnt_q + 8'd1) == total_q);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign wr_ready   = wr_ready_q;
    assign data_send  = data_q;
    assign ctrl_logic = ctrl_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: doc/matrix_stream_tx.md
# matrix_stream_tx

Transmit side of the matrix-loader byte protocol. Buffers element bytes from a host-side write port, accepts a frame command carrying two matrix shapes, and emits a contiguous frame on `data_send`/`ctrl_logic`: frame marker, four dimension bytes, then all elements of both matrices. It sits between the host/IO front end and the loader/multiplier and drives the loader's input pins directly.

## Interface
- `DATA_W`, 8: element and dimension byte width.
- `MAX_DIM`, 4: largest legal row or column count.
- `DEPTH`, 32: element buffer depth; must be ≥ 2·MAX_DIM².
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST_N`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  frame command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_r1`, `cmd_c1`, `cmd_r2`, `cmd_c2`  in  8 each  matrix 1 rows/cols, matrix 2 rows/cols.
- `wr_valid`  in  1  element byte offered.
- `wr_ready`  out  1  buffer not full.
- `wr_data`  in  DATA_W  element byte, row-major, matrix 1 then matrix 2.
- `data_send`  out  DATA_W  protocol data byte.
- `ctrl_logic`  out  2  protocol code: 2 = marker/idle, 1 = dimension byte, 0 = element byte; 3 never driven.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse, last element on the bus.
- `err`  out  1  one-cycle pulse, command rejected.
- `fifo_count`  out  clog2(DEPTH+1)  bytes buffered.

## Operation
- Buffer: synchronous FIFO, DEPTH × DATA_W. Push on `wr_valid && wr_ready`; `wr_ready = (fifo_count < DEPTH)`. Pop only in DATA. Push and pop in the same cycle leave the count unchanged; push is allowed during a frame.
- Command legal iff all four dims are in 1..MAX_DIM and `cmd_c1 == cmd_r2`. TOTAL = R1·C1 + R2·C2, 8-bit unsigned, maximum 2·MAX_DIM².
- States:
  - IDLE: `ctrl_logic=2`, `data_send=0`, `cmd_ready=1`. A legal command latches its dims and moves to WAIT. An illegal command pulses `err` on the next cycle and stays in IDLE; the buffer is untouched.
  - WAIT: `ctrl_logic=2`, `data_send=0`, `cmd_ready=0`. Moves to HDR once `fifo_count ≥ TOTAL`.
  - HDR: four cycles with `ctrl_logic=1`, `data_send` = R1, C1, R2, C2 in that order; a 2-bit index selects the byte.
  - DATA: TOTAL cycles with `ctrl_logic=0`, `data_send` = FIFO head, one pop per cycle, no gaps. `done` is high alongside the last element. Then IDLE.
- Elements are never emitted before the whole frame is buffered, so the data phase never stalls. The protocol has no hold code.
- Excess buffered bytes stay for the next frame.

## Timing
- All outputs are registered.
- Reset values: `ctrl_logic=2`, `data_send=0`, `cmd_ready=1`, `wr_ready=1`, `busy=0`, `done=0`, `err=0`, `fifo_count=0`, state IDLE.
- Command accepted at edge k. WAIT is visible after k. If the buffer already holds TOTAL bytes, `ctrl_logic=1` with R1 is visible after edge k+1, and the first element after edge k+5.
- Frame length on the bus: 4 + TOTAL cycles of non-2 codes. There are at least 2 cycles of `ctrl_logic=2` between frames: IDLE for 1 cycle plus WAIT for ≥1 cycle.
- `done` and `err` are exactly one cycle wide.
- RST_N asserted mid-frame clears the FIFO and state immediately. Outputs return to their reset values asynchronously, and the partial frame is abandoned.
- `fifo_count` reflects pushes one cycle after the accepting edge.

## Test plan
- 2×2 · 2×2, 8 bytes pre-loaded (e.g. 0x24,0x81,0x09,0x63,0x0D,0x8D,0x65,0x12), then command → bus shows 2, 1×4 (2,2,2,2), 0×8 with those bytes in order, 2; `done` on the 8th byte; `fifo_count` = 0.
- Command 2×2 · 2×2 with 3 bytes buffered → `ctrl_logic` holds 2 with `busy=1`. Push 5 more → header starts 1 cycle after count reaches 8.
- Illegal commands (R1=0; C1=3, R2=2; R1=5) → `err` pulse each, bus stays at 2, `fifo_count` unchanged.
- 32 pushes with `wr_valid` held → `wr_ready` drops at count 32 and the 33rd byte is not accepted. Then a 4×4 · 4×4 command → 32 elements back-to-back; `wr_ready` rises after the first pop.
- Two 2×2 · 2×2 frames back-to-back with all 16 bytes pre-loaded → exactly 2 marker cycles between frames; the second frame carries bytes 9–16.
- RST_N low during the 3rd DATA cycle → `ctrl_logic=2`, `data_send=0`, `fifo_count=0` immediately. After release, a fresh frame transmits correctly.
